// File: rtl/device_axil_bridge.sv
// Bridges the core's uncached device strobe/ready port onto a single-outstanding AXI4-Lite master.
// Each accepted strobe issues exactly one AXI read or write and returns exactly one ready pulse.
module device_axil_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    dev_strobe_i,
  input  logic [ADDR_WIDTH-1:0]   dev_addr_i,
  input  logic                    dev_rw_i,
  input  logic [DATA_WIDTH/8-1:0] dev_byte_enable_i,
  input  logic [DATA_WIDTH-1:0]   dev_data_i,
  output logic                    dev_data_ready_o,
  output logic [DATA_WIDTH-1:0]   dev_data_o,
  output logic                    dev_bus_err_o,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,
  output logic [2:0]              dbg_state_o
);

  // Handshake rule on every channel: a transfer happens on a rising clk_i edge where
  // VALID && READY are both 1; VALID, once raised, holds with stable payload until then.
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic                    bready_q, bready_d;
  logic                    rready_q, rready_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dev_strobe_i) begin
          addr_d  = dev_addr_i;
          wdata_d = dev_data_i;
          wstrb_d = dev_byte_enable_i;
          if (dev_rw_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave once neither is still pending.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d = 1'b0;
          ready_d  = 1'b1;
          err_d    = (M_AXI_BRESP != 2'b00);
          state_d  = IDLE;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        // Read data is returned even when the slave flags an error.
        if (M_AXI_RVALID) begin
          rdata_d  = M_AXI_RDATA;
          rready_d = 1'b0;
          ready_d  = 1'b1;
          err_d    = (M_AXI_RRESP != 2'b00);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign dev_data_ready_o = ready_q;
  assign dev_data_o       = rdata_q;
  assign dev_bus_err_o    = err_q;
  assign M_AXI_AWADDR     = addr_q;
  assign M_AXI_AWPROT     = 3'b000;
  assign M_AXI_AWVALID    = awvalid_q;
  assign M_AXI_WDATA      = wdata_q;
  assign M_AXI_WSTRB      = wstrb_q;
  assign M_AXI_WVALID     = wvalid_q;
  assign M_AXI_BREADY     = bready_q;
  assign M_AXI_ARADDR     = addr_q;
  assign M_AXI_ARPROT     = 3'b000;
  assign M_AXI_ARVALID    = arvalid_q;
  assign M_AXI_RREADY     = rready_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_device_axil_bridge.sv
// Bench for device_axil_bridge: directed latency/error/reset cases, then randomized
// mixed traffic against a transaction-level model with an in-order scoreboard.
module tb_device_axil_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dev_strobe_i;
  logic [31:0] dev_addr_i;
  logic        dev_rw_i;
  logic [3:0]  dev_byte_enable_i;
  logic [31:0] dev_data_i;
  logic        dev_data_ready_o;
  logic [31:0] dev_data_o;
  logic        dev_bus_err_o;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic [2:0]  dbg_state_o;

  device_axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dev_strobe_i(dev_strobe_i), .dev_addr_i(dev_addr_i), .dev_rw_i(dev_rw_i),
    .dev_byte_enable_i(dev_byte_enable_i), .dev_data_i(dev_data_i),
    .dev_data_ready_o(dev_data_ready_o), .dev_data_o(dev_data_o), .dev_bus_err_o(dev_bus_err_o),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 clk_i = ~clk_i;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, ready_cnt = 0;
  logic [3:0]  last_wstrb = '0;
  logic [31:0] last_wdata = '0;
  logic        chk_en = 1'b0;
  logic        slave_auto = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- reference model + compare (every negedge) ----------------
  logic [31:0] exp_q[$];
  logic        m_active = 0, m_rw = 0, m_wr_req = 0;
  logic        aw_p = 0, w_p = 0, ar_p = 0, b_p = 0, r_p = 0;
  logic        m_ready = 0, m_err = 0;
  logic [31:0] m_addr = 0, m_data = 0, m_rd = 0;
  logic [3:0]  m_be = 0;
  int          m_acc = 0, m_done = 0;

  initial forever begin
    logic [31:0] e;
    logic        act0;
    @(negedge clk_i);
    if (M_AXI_AWVALID && M_AXI_AWREADY) aw_cnt++;
    if (M_AXI_WVALID && M_AXI_WREADY) begin
      w_cnt++;
      last_wstrb = M_AXI_WSTRB;
      last_wdata = M_AXI_WDATA;
    end
    if (M_AXI_ARVALID && M_AXI_ARREADY) ar_cnt++;
    if (dev_data_ready_o) ready_cnt++;
    if (chk_en) begin
      chk("ready", dev_data_ready_o, m_ready);
      chk("bus_err", dev_bus_err_o, m_ready ? m_err : 1'b0);
      chk("dev_data", dev_data_o, m_rd);
      chk("valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, {aw_p, w_p, ar_p});
      chk("resp_readys", {M_AXI_BREADY, M_AXI_RREADY}, {b_p, r_p});
      if (aw_p) chk("awaddr", {M_AXI_AWPROT, M_AXI_AWADDR}, {3'b000, m_addr});
      if (w_p) chk("wdata", {M_AXI_WSTRB, M_AXI_WDATA}, {m_be, m_data});
      if (ar_p) chk("araddr", {M_AXI_ARPROT, M_AXI_ARADDR}, {3'b000, m_addr});
      if (m_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sb_data", dev_data_o, e);
        end
      end
      // advance the model with what happens at the coming rising edge
      if (!rst_ni) begin
        m_active = 0; m_wr_req = 0; aw_p = 0; w_p = 0; ar_p = 0; b_p = 0; r_p = 0;
        m_ready = 0; m_err = 0; m_rd = 0;
        exp_q.delete();
      end else begin
        act0 = m_active;
        m_ready = 0;
        m_err = 0;
        if (b_p && M_AXI_BVALID) begin
          b_p = 0; m_ready = 1; m_err = (M_AXI_BRESP != 2'b00); m_active = 0; m_done++;
          exp_q.push_back(m_rd);
        end
        if (r_p && M_AXI_RVALID) begin
          r_p = 0; m_ready = 1; m_err = (M_AXI_RRESP != 2'b00); m_active = 0; m_done++;
          m_rd = M_AXI_RDATA;
          exp_q.push_back(m_rd);
        end
        if (aw_p && M_AXI_AWREADY) aw_p = 0;
        if (w_p && M_AXI_WREADY) w_p = 0;
        if (m_wr_req && !aw_p && !w_p) begin
          m_wr_req = 0; b_p = 1;
        end
        if (ar_p && M_AXI_ARREADY) begin
          ar_p = 0; r_p = 1;
        end
        if (dev_strobe_i && !act0) begin
          m_active = 1; m_acc++;
          m_rw = dev_rw_i; m_addr = dev_addr_i; m_data = dev_data_i; m_be = dev_byte_enable_i;
          if (dev_rw_i) begin
            aw_p = 1; w_p = 1; m_wr_req = 1;
          end else ar_p = 1;
        end
      end
    end
  end

  // ---------------- randomized AXI slave ----------------
  logic s_aw, s_w, s_ar, s_b, s_r;
  logic aw_got = 0, w_got = 0, ar_got = 0;

  initial forever begin
    @(negedge clk_i);
    s_aw = M_AXI_AWVALID && M_AXI_AWREADY;
    s_w  = M_AXI_WVALID && M_AXI_WREADY;
    s_ar = M_AXI_ARVALID && M_AXI_ARREADY;
    s_b  = M_AXI_BVALID && M_AXI_BREADY;
    s_r  = M_AXI_RVALID && M_AXI_RREADY;
    @(posedge clk_i);
    #1;
    if (slave_auto) begin
      if (s_aw) aw_got = 1;
      if (s_w) w_got = 1;
      if (s_ar) ar_got = 1;
      if (s_b) M_AXI_BVALID = 0;
      if (s_r) M_AXI_RVALID = 0;
      if (!M_AXI_BVALID && aw_got && w_got && $urandom_range(0, 2) != 0) begin
        M_AXI_BVALID = 1;
        M_AXI_BRESP = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
        aw_got = 0; w_got = 0;
      end
      if (!M_AXI_RVALID && ar_got && $urandom_range(0, 2) != 0) begin
        M_AXI_RVALID = 1;
        M_AXI_RDATA = $urandom;
        M_AXI_RRESP = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
        ar_got = 0;
      end
      M_AXI_AWREADY = ($urandom_range(0, 3) != 0);
      M_AXI_WREADY  = ($urandom_range(0, 3) != 0);
      M_AXI_ARREADY = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- core-side driver tasks ----------------
  task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    dev_strobe_i = 1; dev_rw_i = rw; dev_addr_i = a; dev_data_i = d; dev_byte_enable_i = be;
    step();
    dev_strobe_i = 0;
  endtask

  // Returns at the negedge of the ready cycle; lat = cycle index counted from strobe cycle 0.
  task automatic wait_ready(input int k0, output int lat);
    lat = -1;
    for (int k = k0; k < k0 + 60; k++) begin
      @(negedge clk_i);
      if (dev_data_ready_o) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, aw0, w0, ar0, rc0, ops, bc;
    logic busy, timeout;
    rst_ni = 0; dev_strobe_i = 0; dev_addr_i = 0; dev_rw_i = 0; dev_byte_enable_i = 0;
    dev_data_i = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BRESP = 0; M_AXI_BVALID = 0;
    M_AXI_ARREADY = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; M_AXI_RVALID = 0;
    repeat (3) step();
    chk_en = 1;
    step();
    rst_ni = 1;
    @(negedge clk_i);
    chk("rst_ctrl", {dev_data_ready_o, dev_bus_err_o, M_AXI_AWVALID, M_AXI_WVALID,
                     M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, dbg_state_o}, 0);
    chk("rst_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 0);
    chk("rst_wdata", {M_AXI_WSTRB, M_AXI_WDATA}, 0);
    chk("rst_rdata", dev_data_o, 0);

    // zero-wait read
    step();
    M_AXI_ARREADY = 1; M_AXI_RVALID = 1; M_AXI_RDATA = 32'h1234_5678; M_AXI_RRESP = 2'b00;
    issue(0, 32'hC000_0010, 32'h0, 4'h0);
    wait_ready(1, lat);
    chk("rd_latency", lat, 3);
    chk("rd_data_lit", dev_data_o, 32'h1234_5678);
    chk("rd_err_lit", dev_bus_err_o, 0);
    step();
    M_AXI_RVALID = 0; M_AXI_ARREADY = 0;

    // write with W accepted three cycles after AW
    aw0 = aw_cnt; w0 = w_cnt; rc0 = ready_cnt;
    M_AXI_AWREADY = 1; M_AXI_WREADY = 0;
    issue(1, 32'hC000_0004, 32'h0000_00A5, 4'b0001);
    @(negedge clk_i);
    chk("wr_valid_c1", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
    step();
    @(negedge clk_i);
    chk("wr_valid_c2", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b01);
    step();
    step();
    M_AXI_WREADY = 1; M_AXI_AWREADY = 0;
    step();
    M_AXI_WREADY = 0; M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
    wait_ready(5, lat);
    chk("wr_latency", lat, 6);
    step();
    M_AXI_BVALID = 0;
    repeat (4) step();
    chk("wr_single_aw", aw_cnt - aw0, 1);
    chk("wr_single_w", w_cnt - w0, 1);
    chk("wr_single_ready", ready_cnt - rc0, 1);
    chk("wr_wstrb_lit", {last_wstrb, last_wdata}, {4'b0001, 32'h0000_00A5});

    // read with SLVERR still returns data
    M_AXI_ARREADY = 1; M_AXI_RVALID = 1; M_AXI_RDATA = 32'hDEAD_BEEF; M_AXI_RRESP = 2'b10;
    issue(0, 32'hC000_0100, 32'h0, 4'h0);
    wait_ready(1, lat);
    chk("slverr_latency", lat, 3);
    chk("slverr_err_lit", dev_bus_err_o, 1);
    chk("slverr_data_lit", dev_data_o, 32'hDEAD_BEEF);
    step();
    M_AXI_RVALID = 0; M_AXI_ARREADY = 0; M_AXI_RRESP = 2'b00;

    // back-to-back: read strobe in the write's ready cycle
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1; M_AXI_RVALID = 1; M_AXI_RDATA = 32'h0BAD_F00D;
    issue(1, 32'hC000_0008, 32'h5555_AAAA, 4'hF);
    step();
    step();
    chk("b2b_ready_c3", dev_data_ready_o, 1);
    dev_strobe_i = 1; dev_rw_i = 0; dev_addr_i = 32'hC000_000C;
    step();
    dev_strobe_i = 0;
    @(negedge clk_i);
    chk("b2b_arvalid", M_AXI_ARVALID, 1);
    wait_ready(2, lat);
    chk("b2b_rd_latency", lat, 3);
    chk("b2b_rd_data_lit", dev_data_o, 32'h0BAD_F00D);
    step();
    M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;

    // strobe while busy is ignored
    aw0 = aw_cnt; rc0 = ready_cnt;
    issue(0, 32'hC000_0020, 32'h0, 4'h0);
    issue(1, 32'hC000_0024, 32'h1, 4'hF);
    step();
    M_AXI_ARREADY = 1; M_AXI_RVALID = 1; M_AXI_RDATA = 32'h0000_0077;
    wait_ready(4, lat);
    step();
    M_AXI_RVALID = 0; M_AXI_ARREADY = 0;
    repeat (3) step();
    chk("busy_no_aw", aw_cnt - aw0, 0);
    chk("busy_one_ready", ready_cnt - rc0, 1);

    // reset while ARVALID is stalled
    rc0 = ready_cnt; ar0 = ar_cnt;
    issue(0, 32'hC000_0030, 32'h0, 4'h0);
    @(negedge clk_i);
    chk("rst_mid_arvalid_pre", M_AXI_ARVALID, 1);
    step();
    rst_ni = 0;
    step();
    rst_ni = 1;
    @(negedge clk_i);
    chk("rst_mid_after", {M_AXI_ARVALID, dev_data_ready_o, dbg_state_o}, 0);
    step();
    M_AXI_ARREADY = 1;
    repeat (3) step();
    M_AXI_ARREADY = 0;
    repeat (2) step();
    chk("rst_mid_no_ready", ready_cnt - rc0, 0);
    chk("rst_mid_no_ar", ar_cnt - ar0, 0);

    // randomized mixed traffic
    aw_got = 0; w_got = 0; ar_got = 0;
    rc0 = ready_cnt; ar0 = m_acc; w0 = m_done;
    slave_auto = 1;
    ops = 0; busy = 0; bc = 0; timeout = 0;
    while ((ops < 1000 || busy) && !timeout) begin
      step();
      dev_strobe_i = 0;
      if (busy && dev_data_ready_o) busy = 0;
      if (busy) begin
        bc++;
        if (bc > 300) timeout = 1;
        else if ($urandom_range(0, 19) == 0) begin
          dev_strobe_i = 1; dev_rw_i = $urandom_range(0, 1);
          dev_addr_i = $urandom; dev_data_i = $urandom; dev_byte_enable_i = $urandom_range(0, 15);
        end
      end else if (ops < 1000 && $urandom_range(0, 2) != 0) begin
        dev_strobe_i = 1; dev_rw_i = $urandom_range(0, 1);
        dev_addr_i = {4'hC, 28'($urandom)}; dev_data_i = $urandom;
        dev_byte_enable_i = $urandom_range(0, 15);
        busy = 1; bc = 0; ops++;
      end
    end
    dev_strobe_i = 0;
    repeat (5) step();
    chk("rand_timeout", timeout, 0);
    chk("rand_accepted", m_acc - ar0, 1000);
    chk("rand_completed", m_done - w0, 1000);
    chk("rand_ready_pulses", ready_cnt - rc0, 1000);
    chk("rand_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
